// File: rtl/i2s_tx_serializer.sv
// ---------------------------------------------------------------------------
// i2s_tx_serializer
//
// I2S master transmitter. Divides the system clock down to the bit clock,
// generates word select, and shifts stereo samples out MSB-first in Philips
// I2S format (data lags WS by one bit clock). Samples arrive through a
// single-entry holding register with a valid/ready handshake; if no fresh
// sample is waiting when a frame begins, the previous sample is repeated and
// an underrun is flagged.
//
// Ports:
//   clk_i           system clock, all logic on the rising edge
//   reset_i         synchronous active-high reset
//   sample_l_i      left channel sample (two's complement, DATA_W bits)
//   sample_r_i      right channel sample (two's complement, DATA_W bits)
//   sample_valid_i  sample pair valid
//   sample_ready_o  holding register empty; transfer on valid & ready
//   i2s_sck_o       bit clock, period 2*CLK_DIV system clocks
//   i2s_ws_o        word select, 0 = left slot, 1 = right slot
//   i2s_sd_o        serial data
//   frame_start_o   one-cycle pulse when a new frame is loaded
//   underrun_o      one-cycle pulse when a frame repeats the last sample
// ---------------------------------------------------------------------------
module i2s_tx_serializer #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 24,
  parameter int SLOT_W  = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] sample_l_i,
  input  logic [DATA_W-1:0] sample_r_i,
  input  logic              sample_valid_i,
  output logic              sample_ready_o,
  output logic              i2s_sck_o,
  output logic              i2s_ws_o,
  output logic              i2s_sd_o,
  output logic              frame_start_o,
  output logic              underrun_o
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W   = $clog2(FRAME_W);

  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BIT_W-1:0]  bit_nxt;
  logic [BIT_W-1:0]  slot_pos;
  logic              div_wrap;
  logic              fall;
  logic              ws_nxt;
  logic              data_bit;
  logic              load;

  logic              hold_full;
  logic [DATA_W-1:0] hold_l;
  logic [DATA_W-1:0] hold_r;
  logic [DATA_W-1:0] last_l;
  logic [DATA_W-1:0] last_r;
  logic [DATA_W-1:0] shift_l;
  logic [DATA_W-1:0] shift_r;

  // A fall event is the divider wrap that takes SCK from high to low; every
  // serial output and frame decision is made only in that cycle.
  assign div_wrap = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign fall     = div_wrap & i2s_sck_o;

  // Position of the bit about to be driven, and its offset inside its slot.
  // Position 0 of each slot is the one-bit I2S delay, so data occupies
  // positions 1..DATA_W and the rest of the slot is padded with zeros.
  assign bit_nxt  = (bit_cnt == BIT_W'(FRAME_W - 1)) ? '0 : bit_cnt + BIT_W'(1);
  assign ws_nxt   = (bit_nxt >= BIT_W'(SLOT_W));
  assign slot_pos = ws_nxt ? (bit_nxt - BIT_W'(SLOT_W)) : bit_nxt;
  assign data_bit = (slot_pos >= BIT_W'(1)) && (slot_pos <= BIT_W'(DATA_W));
  assign load     = fall && (bit_nxt == '0);

  assign sample_ready_o = ~hold_full;

  // Bit clock divider: SCK toggles each time div_cnt wraps.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_cnt   <= '0;
      i2s_sck_o <= 1'b0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
      if (div_wrap) begin
        i2s_sck_o <= ~i2s_sck_o;
      end
    end
  end

  // Serial side: bit counter, WS, SD and the two shift registers. Reset
  // starts bit_cnt at the last position so the first fall event loads a frame.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bit_cnt       <= BIT_W'(FRAME_W - 1);
      i2s_ws_o      <= 1'b1;
      i2s_sd_o      <= 1'b0;
      shift_l       <= '0;
      shift_r       <= '0;
      last_l        <= '0;
      last_r        <= '0;
      frame_start_o <= 1'b0;
      underrun_o    <= 1'b0;
    end else begin
      frame_start_o <= 1'b0;
      underrun_o    <= 1'b0;
      if (fall) begin
        bit_cnt  <= bit_nxt;
        i2s_ws_o <= ws_nxt;
        i2s_sd_o <= 1'b0;
        if (load) begin
          frame_start_o <= 1'b1;
          if (hold_full) begin
            shift_l <= hold_l;
            shift_r <= hold_r;
            last_l  <= hold_l;
            last_r  <= hold_r;
          end else begin
            shift_l    <= last_l;
            shift_r    <= last_r;
            underrun_o <= 1'b1;
          end
        end else if (data_bit) begin
          if (ws_nxt) begin
            i2s_sd_o <= shift_r[DATA_W-1];
            shift_r  <= {shift_r[DATA_W-2:0], 1'b0};
          end else begin
            i2s_sd_o <= shift_l[DATA_W-1];
            shift_l  <= {shift_l[DATA_W-2:0], 1'b0};
          end
        end
      end
    end
  end

  // Holding register. A frame load empties it only if it was full; when it
  // was empty the load takes the underrun path and a sample arriving in the
  // same cycle is kept for the following frame.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
    end else begin
      if (load && hold_full) begin
        hold_full <= 1'b0;
      end else if (sample_valid_i && !hold_full) begin
        hold_l    <= sample_l_i;
        hold_r    <= sample_r_i;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_i2s_tx_serializer
//
// Bench for i2s_tx_serializer. The main instance runs with CLK_DIV=2,
// DATA_W=24, SLOT_W=32; a second instance runs with CLK_DIV=1, DATA_W=16.
// Expected frames are queued when samples are handed over (or when a repeat
// is known to be due) and a monitor pops them at each frame start, assembling
// the 64 serial bits of the frame and comparing them at its end.
// ---------------------------------------------------------------------------
module tb_i2s_tx_serializer;

  localparam int CLK_DIV    = 2;
  localparam int DW         = 24;
  localparam int FRAME_CLKS = 2 * CLK_DIV * 64;
  localparam logic [63:0] WS_PAT = 64'hFFFF_FFFF_0000_0000;

  typedef struct packed {
    logic [23:0] l;
    logic [23:0] r;
    logic        ur;
  } frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic          reset = 1'b1;
  logic [DW-1:0] sample_l = '0;
  logic [DW-1:0] sample_r = '0;
  logic          valid = 1'b0;
  logic          ready, sck, ws, sd, frame_start, underrun;

  // small-configuration instance
  logic          rst6 = 1'b1;
  logic [15:0]   l6 = '0;
  logic [15:0]   r6 = '0;
  logic          valid6 = 1'b0;
  logic          ready6, sck6, ws6, sd6, fs6, ur6;

  int chk = 0;
  int fails = 0;

  frame_t      exp_q[$];
  logic [63:0] exp6_q[$];

  i2s_tx_serializer #(.CLK_DIV(CLK_DIV), .DATA_W(DW), .SLOT_W(32)) dut (
    .clk_i(clk), .reset_i(reset),
    .sample_l_i(sample_l), .sample_r_i(sample_r),
    .sample_valid_i(valid), .sample_ready_o(ready),
    .i2s_sck_o(sck), .i2s_ws_o(ws), .i2s_sd_o(sd),
    .frame_start_o(frame_start), .underrun_o(underrun)
  );

  i2s_tx_serializer #(.CLK_DIV(1), .DATA_W(16), .SLOT_W(32)) dut6 (
    .clk_i(clk), .reset_i(rst6),
    .sample_l_i(l6), .sample_r_i(r6),
    .sample_valid_i(valid6), .sample_ready_o(ready6),
    .i2s_sck_o(sck6), .i2s_ws_o(ws6), .i2s_sd_o(sd6),
    .frame_start_o(fs6), .underrun_o(ur6)
  );

  // Expected serial bits of one frame, indexed by fall number from the
  // frame start: data at falls 1..dw of each slot, MSB first.
  function automatic logic [63:0] sd_pattern(input logic [23:0] l, input logic [23:0] r,
                                             input int dw);
    logic [63:0] p;
    p = '0;
    for (int n = 1; n <= dw; n++) begin
      p[n]      = l[dw-n];
      p[32 + n] = r[dw-n];
    end
    return p;
  endfunction

  // Frame monitor for the main instance: checks pulses only occur on falls,
  // pops the expected frame at each frame start and checks the assembled
  // bits when the 64th fall of the frame arrives.
  logic        mon_en = 1'b0;
  logic        mon_abort = 1'b0;
  logic        prev_sck = 1'b0;
  int          fall_idx = -1;
  logic [63:0] cap_sd = '0;
  logic [63:0] cap_ws = '0;
  frame_t      cur;
  logic        have_cur = 1'b0;
  int          frames_done = 0;

  always @(negedge clk) begin
    if (mon_abort) begin
      fall_idx  = -1;
      have_cur  = 1'b0;
      prev_sck  = 1'b0;
      mon_abort = 1'b0;
    end
    if (prev_sck && !sck) begin
      if (frame_start) begin
        if (mon_en && fall_idx != -1) begin
          chk++;
          if (fall_idx != 64) begin
            fails++;
            $display("[TB] FAIL short_frame: frame start at fall %0d, required after fall 63", fall_idx);
          end
        end
        fall_idx = 0;
        cap_sd   = '0;
        cap_ws   = '0;
        have_cur = 1'b0;
        if (mon_en) begin
          chk++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("[TB] FAIL frame_expected: frame started with no frame queued");
          end else begin
            cur      = exp_q.pop_front();
            have_cur = 1'b1;
            chk++;
            if (underrun !== cur.ur) begin
              fails++;
              $display("[TB] FAIL frame_underrun: got %b required %b", underrun, cur.ur);
            end
          end
        end
      end else if (fall_idx == 64) begin
        if (mon_en) begin
          chk++;
          fails++;
          $display("[TB] FAIL long_frame: no frame start after fall 63");
        end
        fall_idx = -1;
      end else if (fall_idx >= 0) begin
        fall_idx++;
      end
      if (fall_idx >= 0 && fall_idx <= 63) begin
        cap_sd[fall_idx] = sd;
        cap_ws[fall_idx] = ws;
      end
      if (fall_idx == 63) begin
        if (have_cur) begin
          chk++;
          if (cap_sd !== sd_pattern(cur.l, cur.r, DW)) begin
            fails++;
            $display("[TB] FAIL frame_sd: got %h required %h", cap_sd, sd_pattern(cur.l, cur.r, DW));
          end
          chk++;
          if (cap_ws !== WS_PAT) begin
            fails++;
            $display("[TB] FAIL frame_ws: got %h required %h", cap_ws, WS_PAT);
          end
          frames_done++;
        end
        fall_idx = 64;
        have_cur = 1'b0;
      end
      if (mon_en && underrun && !frame_start) begin
        chk++;
        fails++;
        $display("[TB] FAIL underrun_alone: underrun without frame start");
      end
    end else if (mon_en) begin
      chk++;
      if (frame_start || underrun) begin
        fails++;
        $display("[TB] FAIL pulse_off_fall: frame_start=%b underrun=%b, required 0 0", frame_start, underrun);
      end
    end
    prev_sck = sck;
  end

  // Called at a falling clock edge; returns at the falling edge that shows
  // the next frame start, or after limit clocks.
  task automatic wait_frame(input int limit, output bit ok, output int clks);
    ok   = 1'b0;
    clks = 0;
    while (!ok && clks < limit) begin
      @(negedge clk);
      clks++;
      if (frame_start) ok = 1'b1;
    end
  endtask

  // Offers a sample pair until accepted; the frame it will occupy is queued
  // the moment the handshake is seen.
  task automatic push_sample(input logic [23:0] l, input logic [23:0] r, input int limit,
                             output bit ok);
    sample_l = l;
    sample_r = r;
    valid    = 1'b1;
    ok       = 1'b0;
    for (int n = 0; n < limit && !ok; n++) begin
      if (ready) begin
        ok = 1'b1;
        exp_q.push_back('{l, r, 1'b0});
      end
      @(negedge clk);
    end
    valid = 1'b0;
  endtask

  task automatic test_reset();
    int rise_at;
    int fs_at;
    reset = 1'b1;
    valid = 1'b0;
    repeat (3) @(negedge clk);
    chk++;
    if ({sck, ws, sd, ready, frame_start, underrun} !== 6'b010100) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got %b required 010100",
               {sck, ws, sd, ready, frame_start, underrun});
    end
    exp_q.push_back('{24'h0, 24'h0, 1'b1});
    mon_en  = 1'b1;
    reset   = 1'b0;
    rise_at = 0;
    fs_at   = 0;
    for (int c = 1; c <= 40 && fs_at == 0; c++) begin
      @(negedge clk);
      if (sck && rise_at == 0) rise_at = c;
      if (frame_start) fs_at = c;
    end
    chk++;
    if (rise_at != CLK_DIV) begin
      fails++;
      $display("[TB] FAIL first_sck_rise: clock %0d required %0d", rise_at, CLK_DIV);
    end
    chk++;
    if (fs_at != 2 * CLK_DIV) begin
      fails++;
      $display("[TB] FAIL first_frame_start: clock %0d required %0d", fs_at, 2 * CLK_DIV);
    end
    chk++;
    if ({ws, underrun} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL first_frame_ws_underrun: got %b required 01", {ws, underrun});
    end
  endtask

  task automatic test_basic_frame();
    bit ok;
    int clks;
    push_sample(24'hABCDEF, 24'h123456, 20, ok);
    chk++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL push_accept: sample not accepted within 20 clocks");
    end
    chk++;
    if (ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ready_after_accept: got %b required 0", ready);
    end
    wait_frame(FRAME_CLKS + 16, ok, clks);
    chk++;
    if (!ok || ready !== 1'b1 || underrun !== 1'b0) begin
      fails++;
      $display("[TB] FAIL frame2_start: seen=%0d ready=%b underrun=%b required 1 1 0", ok, ready, underrun);
    end
  endtask

  task automatic test_underrun_repeat();
    int ur_cnt;
    int clks;
    bit found;
    exp_q.push_back('{24'hABCDEF, 24'h123456, 1'b1});
    ur_cnt = 0;
    clks   = 0;
    found  = 1'b0;
    while (!found && clks < FRAME_CLKS + 16) begin
      @(negedge clk);
      clks++;
      if (underrun) ur_cnt++;
      if (frame_start) found = 1'b1;
    end
    chk++;
    if (!found || clks != FRAME_CLKS) begin
      fails++;
      $display("[TB] FAIL frame_period: %0d clocks required %0d", clks, FRAME_CLKS);
    end
    chk++;
    if (ur_cnt != 1 || underrun !== 1'b1) begin
      fails++;
      $display("[TB] FAIL underrun_once: %0d pulses, at start %b, required 1 and 1", ur_cnt, underrun);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int leak;
    int clks;
    push_sample(24'h800000, 24'hFFFFFF, 20, ok);
    chk++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL push_first: sample not accepted within 20 clocks");
    end
    sample_l = 24'h000001;
    sample_r = 24'h7FFFFF;
    valid    = 1'b1;
    leak     = 0;
    clks     = 0;
    ok       = 1'b0;
    while (!ok && clks < FRAME_CLKS + 16) begin
      if (ready) leak++;
      @(negedge clk);
      clks++;
      if (frame_start) ok = 1'b1;
    end
    chk++;
    if (!ok || leak != 0) begin
      fails++;
      $display("[TB] FAIL ready_held_low: frame seen=%0d, ready high on %0d clocks, required 1 and 0", ok, leak);
    end
    chk++;
    if (ready !== 1'b1 || underrun !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ready_at_frame_start: ready=%b underrun=%b required 1 0", ready, underrun);
    end
    exp_q.push_back('{24'h000001, 24'h7FFFFF, 1'b0});
    @(negedge clk);
    valid = 1'b0;
    chk++;
    if (ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL second_accept: ready=%b required 0 one clock after frame start", ready);
    end
  endtask

  task automatic test_mid_reset();
    bit   ok;
    int   clks;
    int   falls;
    logic prev;
    wait_frame(FRAME_CLKS + 16, ok, clks);
    exp_q.push_back('{24'h000001, 24'h7FFFFF, 1'b1});
    wait_frame(FRAME_CLKS + 16, ok, clks);
    chk++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL frame6_start: not seen within %0d clocks", FRAME_CLKS + 16);
    end
    falls = 0;
    prev  = sck;
    for (int n = 0; n < 200 && falls < 10; n++) begin
      @(negedge clk);
      if (prev && !sck) falls++;
      prev = sck;
    end
    reset     = 1'b1;
    mon_abort = 1'b1;
    exp_q.push_back('{24'h0, 24'h0, 1'b1});
    @(negedge clk);
    reset = 1'b0;
    chk++;
    if ({sck, ws, sd, ready, frame_start, underrun} !== 6'b010100) begin
      fails++;
      $display("[TB] FAIL mid_reset_outputs: got %b required 010100",
               {sck, ws, sd, ready, frame_start, underrun});
    end
    chk++;
    if (frames_done != 5) begin
      fails++;
      $display("[TB] FAIL frames_before_reset: %0d checked frames required 5", frames_done);
    end
    wait_frame(40, ok, clks);
    chk++;
    if (!ok || clks != 2 * CLK_DIV || underrun !== 1'b1) begin
      fails++;
      $display("[TB] FAIL restart_frame: seen=%0d after %0d clocks underrun=%b required 1 %0d 1",
               ok, clks, underrun, 2 * CLK_DIV);
    end
    clks = 0;
    while (frames_done < 6 && clks < FRAME_CLKS + 16) begin
      @(negedge clk);
      clks++;
    end
    mon_en = 1'b0;
    chk++;
    if (frames_done != 6 || exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL restart_frame_done: %0d frames, %0d queued, required 6 and 0",
               frames_done, exp_q.size());
    end
  endtask

  task automatic test_small_config();
    logic [63:0] c_sd;
    logic [63:0] c_ws;
    logic [63:0] expv;
    int          clks;
    int          idx;
    int          toggle_err;
    bit          found;
    logic        prev;
    rst6  = 1'b0;
    found = 1'b0;
    clks  = 0;
    while (!found && clks < 40) begin
      @(negedge clk);
      clks++;
      if (fs6) found = 1'b1;
    end
    chk++;
    if (!found || clks != 2 || ur6 !== 1'b1) begin
      fails++;
      $display("[TB] FAIL small_first_frame: seen=%0d after %0d clocks underrun=%b required 1 2 1", found, clks, ur6);
    end
    l6     = 16'hA5C3;
    r6     = 16'h3C5A;
    valid6 = 1'b1;
    chk++;
    if (ready6 !== 1'b1) begin
      fails++;
      $display("[TB] FAIL small_ready: got %b required 1", ready6);
    end
    exp6_q.push_back(sd_pattern(24'h00A5C3, 24'h003C5A, 16));
    @(negedge clk);
    valid6 = 1'b0;
    clks   = 1;
    found  = 1'b0;
    while (!found && clks < 300) begin
      @(negedge clk);
      clks++;
      if (fs6) found = 1'b1;
    end
    chk++;
    if (!found || clks != 128 || ur6 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL small_frame_period: %0d clocks underrun=%b required 128 0", clks, ur6);
    end
    c_sd       = '0;
    c_ws       = '0;
    c_sd[0]    = sd6;
    c_ws[0]    = ws6;
    idx        = 1;
    toggle_err = 0;
    prev       = sck6;
    for (int c = 0; c < 127; c++) begin
      @(negedge clk);
      if (sck6 === prev) toggle_err++;
      if (prev && !sck6 && idx < 64) begin
        c_sd[idx] = sd6;
        c_ws[idx] = ws6;
        idx++;
      end
      prev = sck6;
    end
    chk++;
    if (toggle_err != 0 || idx != 64) begin
      fails++;
      $display("[TB] FAIL small_sck: %0d missed toggles, %0d falls, required 0 and 64", toggle_err, idx);
    end
    expv = exp6_q.pop_front();
    chk++;
    if (c_sd !== expv) begin
      fails++;
      $display("[TB] FAIL small_frame_sd: got %h required %h", c_sd, expv);
    end
    chk++;
    if (c_ws !== WS_PAT) begin
      fails++;
      $display("[TB] FAIL small_frame_ws: got %h required %h", c_ws, WS_PAT);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_underrun_repeat();
    test_back_to_back();
    test_mid_reset();
    test_small_config();
    $display("End of test - %0d assertions evaluated, %0d failures", chk, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish within 500000 time units");
    $fatal(1, "[TB] timeout");
  end

endmodule
